// File: rtl/store_buffer_if.sv
// Store-enqueue, load-probe and dcache-write signals of the store buffer.
// master = memory_stage/dcache side, slave = store_buffer.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_is_byte;
    logic              st_ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_is_byte;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              ld_conflict;

    logic              dc_wr_valid;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic              dc_wr_byte;
    logic              dc_wr_ready;

    modport master (
        output st_valid, st_addr, st_data, st_is_byte,
        input  st_ready,
        output ld_valid, ld_addr, ld_is_byte,
        input  ld_hit, ld_data, ld_conflict,
        input  dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_byte,
        output dc_wr_ready
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_is_byte,
        output st_ready,
        input  ld_valid, ld_addr, ld_is_byte,
        output ld_hit, ld_data, ld_conflict,
        output dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_byte,
        input  dc_wr_ready
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between memory_stage and the dcache write port, with
// youngest-match store-to-load forwarding and a conservative conflict flag.
module store_buffer #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    store_buffer_if.slave        bus,
    output logic                 empty,
    output logic                 full
);
    localparam int PTR_W = $clog2(ENTRIES);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              is_byte;
    } entry_t;

    entry_t             mem [ENTRIES];
    logic [ENTRIES-1:0] vld;
    ptr_t               head, tail;
    logic [PTR_W:0]     count;

    logic   push, pop, cnt_empty, cnt_full;
    logic   y_found;
    ptr_t   y_idx, idx;
    entry_t y;

    assign cnt_empty = (count == '0);
    assign cnt_full  = (count == (PTR_W+1)'(ENTRIES));

    assign empty           = rst || cnt_empty;
    assign full            = !rst && cnt_full;
    assign bus.st_ready    = !cnt_full && !rst;
    assign bus.dc_wr_valid = !cnt_empty && !rst;
    assign bus.dc_wr_addr  = mem[head].addr;
    assign bus.dc_wr_data  = mem[head].data;
    assign bus.dc_wr_byte  = mem[head].is_byte;

    assign push = bus.st_valid && bus.st_ready;
    assign pop  = bus.dc_wr_valid && bus.dc_wr_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + ptr_t'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + ptr_t'(1);
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // NOTE: entry storage is not reset; the valid bits alone decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{addr: bus.st_addr, data: bus.st_data, is_byte: bus.st_is_byte};
        end
    end

    // Walk oldest to youngest so the last word match left standing is the youngest.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        y_found = 1'b0;
        y_idx   = '0;
        idx     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            idx = head + ptr_t'(i);
            if (vld[idx] && mem[idx].addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]) begin
                y_found = 1'b1;
                y_idx   = idx;
            end
        end
    end

    always_comb begin
        bus.ld_hit      = 1'b0;
        bus.ld_conflict = 1'b0;
        bus.ld_data     = '0;
        y               = mem[y_idx];
        if (!rst && bus.ld_valid && y_found) begin
            if (!y.is_byte) begin
                bus.ld_hit  = 1'b1;
                bus.ld_data = bus.ld_is_byte ? DATA_W'(y.data[{bus.ld_addr[1:0], 3'b000} +: 8])
                                             : y.data;
            end else if (bus.ld_is_byte && y.addr == bus.ld_addr) begin
                bus.ld_hit  = 1'b1;
                bus.ld_data = DATA_W'(y.data[7:0]);
            end else begin
                // Partial overlap: no byte merging, memory_stage stalls until it drains.
                bus.ld_conflict = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_store_buffer;
    localparam int ENTRIES = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic empty, full;

    store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) sb ();

    store_buffer #(.ENTRIES(ENTRIES), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (sb.slave),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } st_t;

    st_t q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest word match decides: whole-word store forwards, matching byte/byte forwards,
    // anything else overlapping is a conflict.
    function automatic void model_probe(input logic [31:0] a, input logic b,
                                        output logic hit, output logic conf,
                                        output logic [31:0] d);
        bit found = 0;
        hit = 0; conf = 0; d = 0;
        for (int i = q.size() - 1; i >= 0 && !found; i--) begin
            if (q[i].addr[31:2] == a[31:2]) begin
                found = 1;
                if (!q[i].is_byte) begin
                    hit = 1;
                    d   = b ? ((q[i].data >> (8 * a[1:0])) & 32'hFF) : q[i].data;
                end else if (b && q[i].addr == a) begin
                    hit = 1;
                    d   = {24'h0, q[i].data[7:0]};
                end else begin
                    conf = 1;
                end
            end
        end
    endfunction

    task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic b);
        sb.st_valid = v; sb.st_addr = a; sb.st_data = d; sb.st_is_byte = b;
    endtask

    task automatic set_load(input logic v, input logic [31:0] a, input logic b);
        sb.ld_valid = v; sb.ld_addr = a; sb.ld_is_byte = b;
    endtask

    // Check all outputs against the model, then clock once and update the model.
    task automatic tick();
        logic        e_hit, e_conf;
        logic [31:0] e_data;
        bit          do_push, do_pop;
        st_t         s;
        string       t;
        #1;
        t = $sformatf("cyc%0d", cyc);
        if (rst) begin
            check({t, " rst st_ready"}, 32'(sb.st_ready), 0);
            check({t, " rst dc_wr_valid"}, 32'(sb.dc_wr_valid), 0);
            check({t, " rst empty"}, 32'(empty), 1);
            check({t, " rst full"}, 32'(full), 0);
            check({t, " rst ld_hit"}, 32'(sb.ld_hit), 0);
            check({t, " rst ld_conflict"}, 32'(sb.ld_conflict), 0);
            check({t, " rst ld_data"}, sb.ld_data, 0);
        end else begin
            check({t, " st_ready"}, 32'(sb.st_ready), 32'(q.size() < ENTRIES));
            check({t, " full"}, 32'(full), 32'(q.size() == ENTRIES));
            check({t, " empty"}, 32'(empty), 32'(q.size() == 0));
            check({t, " dc_wr_valid"}, 32'(sb.dc_wr_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check({t, " dc_wr_addr"}, sb.dc_wr_addr, q[0].addr);
                check({t, " dc_wr_data"}, sb.dc_wr_data, q[0].data);
                check({t, " dc_wr_byte"}, 32'(sb.dc_wr_byte), 32'(q[0].is_byte));
            end
            if (sb.ld_valid) model_probe(sb.ld_addr, sb.ld_is_byte, e_hit, e_conf, e_data);
            else begin e_hit = 0; e_conf = 0; e_data = 0; end
            check({t, " ld_hit"}, 32'(sb.ld_hit), 32'(e_hit));
            check({t, " ld_conflict"}, 32'(sb.ld_conflict), 32'(e_conf));
            if (e_hit) check({t, " ld_data"}, sb.ld_data, e_data);
        end
        do_push = !rst && sb.st_valid && q.size() < ENTRIES;
        do_pop  = !rst && sb.dc_wr_ready && q.size() > 0;
        s = '{addr: sb.st_addr, data: sb.st_data, is_byte: sb.st_is_byte};
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(s);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        sb.dc_wr_ready = 1;
        for (int k = 0; k < 16 && q.size() > 0; k++) tick();
        sb.dc_wr_ready = 0;
        #1;
        check("drain empty", 32'(empty), 1);
    endtask

    initial begin
        set_store(0, 0, 0, 0);
        set_load(0, 0, 0);
        sb.dc_wr_ready = 0;
        @(negedge clk);

        // Reset values, including a probe and a store offered during reset.
        set_load(1, 32'h100, 0);
        set_store(1, 32'h100, 32'h1, 0);
        tick(); tick();
        rst = 0;
        set_load(0, 0, 0);

        // Push and hold against a stalled dcache.
        set_store(1, 32'h100, 32'hDEADBEEF, 0);
        tick();
        set_store(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold dc_wr_valid", 32'(sb.dc_wr_valid), 1);
            check("hold dc_wr_data", sb.dc_wr_data, 32'hDEADBEEF);
            tick();
        end
        sb.dc_wr_ready = 1;
        tick();
        sb.dc_wr_ready = 0;
        #1;
        check("pop empty", 32'(empty), 1);

        // Fill, offer a fifth store, then pop while a store waits.
        for (int k = 0; k < 4; k++) begin
            set_store(1, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k), 0);
            tick();
        end
        set_store(1, 32'h410, 32'h55, 0);
        #1;
        check("full flag", 32'(full), 1);
        check("full st_ready", 32'(sb.st_ready), 0);
        tick();
        sb.dc_wr_ready = 1;
        tick();
        sb.dc_wr_ready = 0;
        tick();
        #1;
        check("refill full", 32'(full), 1);
        // Push and pop together at count 3 keeps the count unchanged.
        sb.dc_wr_ready = 1;
        set_store(0, 0, 0, 0);
        tick();
        set_store(1, 32'h420, 32'h77, 0);
        tick();
        set_store(0, 0, 0, 0);
        drain();

        // Youngest word store forwards, whole and by byte.
        set_store(1, 32'h200, 32'h11223344, 0); tick();
        set_store(1, 32'h200, 32'hAABBCCDD, 0); tick();
        set_store(0, 0, 0, 0);
        set_load(1, 32'h200, 0);
        #1;
        check("fwd word hit", 32'(sb.ld_hit), 1);
        check("fwd word data", sb.ld_data, 32'hAABBCCDD);
        tick();
        set_load(1, 32'h202, 1);
        #1;
        check("fwd byte data", sb.ld_data, 32'h000000BB);
        tick();
        drain();

        // Byte store: exact byte load forwards, word load conflicts until drained.
        set_store(1, 32'h301, 32'hFFFFFF5A, 1); tick();
        set_store(0, 0, 0, 0);
        set_load(1, 32'h301, 1);
        #1;
        check("sb fwd hit", 32'(sb.ld_hit), 1);
        check("sb fwd data", sb.ld_data, 32'h5A);
        tick();
        set_load(1, 32'h300, 0);
        #1;
        check("sb word conflict", 32'(sb.ld_conflict), 1);
        tick(); tick();
        drain();
        check("after drain conflict", 32'(sb.ld_conflict), 0);
        check("after drain hit", 32'(sb.ld_hit), 0);

        // A store pushed in the probe cycle is invisible until the next cycle.
        set_store(1, 32'h500, 32'hCAFEF00D, 0);
        set_load(1, 32'h500, 0);
        #1;
        check("same-cycle no hit", 32'(sb.ld_hit), 0);
        tick();
        set_store(0, 0, 0, 0);
        #1;
        check("next-cycle hit", 32'(sb.ld_hit), 1);
        tick();
        set_load(0, 0, 0);
        drain();

        // Reset with pending entries discards them with no handshake.
        for (int k = 0; k < 3; k++) begin
            set_store(1, 32'h700 + 32'(4 * k), 32'h9 + 32'(k), 0);
            tick();
        end
        set_store(0, 0, 0, 0);
        rst = 1;
        sb.dc_wr_ready = 1;
        tick();
        rst = 0;
        #1;
        check("post-rst empty", 32'(empty), 1);
        check("post-rst dc_wr_valid", 32'(sb.dc_wr_valid), 0);
        tick();
        sb.dc_wr_ready = 0;

        // Random traffic on a narrow address window to provoke matches and conflicts.
        for (int n = 0; n < 400; n++) begin
            logic        b;
            logic [31:0] a;
            b = 1'($urandom_range(0, 1));
            a = 32'h600 + 32'($urandom_range(0, 15));
            if (!b) a[1:0] = 2'b00;
            set_store(1'($urandom_range(0, 2) != 0), a, $urandom, b);
            set_load(1'($urandom_range(0, 3) != 0), 32'h600 + 32'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            sb.dc_wr_ready = 1'($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0;
        set_store(0, 0, 0, 0);
        set_load(0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
